// File: rtl/counter_pkg.sv
// Shared constants, digit type and clamp helper for the modulo digit counter chain.
package counter_pkg;

    localparam int unsigned DIGIT_W_DEF = 4;
    localparam int unsigned DIGIT_W_MAX = 8;
    localparam logic [7:0]  MOD_60      = {4'd6, 4'd10};

    typedef logic [DIGIT_W_MAX-1:0] digit_t;

    // A modulus field of 0 wraps the subtraction to all-ones, which encodes 2**DIGIT_W.
    function automatic digit_t clamp_digit(input digit_t val, input digit_t modulus);
        digit_t max_v;
        max_v = modulus - digit_t'(1);
        return (val > max_v) ? max_v : val;
    endfunction

endpackage

// File: rtl/mod_counter_chain_if.sv
// Control and status bundle of the counter chain; W is NUM_DIGITS*DIGIT_W.
interface mod_counter_chain_if #(
    parameter int unsigned W = 8
) ();

    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         co;
    logic         wrap;
    logic         load_err;

    modport master (
        output en, up_dn, load, load_val,
        input  count, co, wrap, load_err
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, co, wrap, load_err
    );

endinterface

// File: rtl/mod_digit.sv
// One modulo-M digit: load with clamp, step up/down with wrap, exposes its next value.
module mod_digit
    import counter_pkg::*;
#(
    parameter int unsigned DIGIT_W = DIGIT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic               up_dn,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic [DIGIT_W-1:0] modulus,
    output logic [DIGIT_W-1:0] q,
    output logic [DIGIT_W-1:0] q_nxt_c,
    output logic               at_max,
    output logic               at_zero,
    output logic               clamped
);

    logic [DIGIT_W-1:0] max_c;
    logic [DIGIT_W-1:0] ld_c;

    assign max_c   = modulus - DIGIT_W'(1);
    assign ld_c    = DIGIT_W'(clamp_digit(digit_t'(load_val), digit_t'(modulus)));
    assign at_max  = (q == max_c);
    assign at_zero = (q == '0);
    assign clamped = (ld_c != load_val);

    // Load has priority; a step only happens when the lower digits enable it.
    always_comb begin
        q_nxt_c = q;
        if (load) begin
            q_nxt_c = ld_c;
        end else if (step) begin
            if (up_dn) begin
                q_nxt_c = at_max ? '0 : q + DIGIT_W'(1);
            end else begin
                q_nxt_c = at_zero ? max_c : q - DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_nxt_c;
        end
    end

endmodule

// File: rtl/mod_counter_chain.sv
// Cascade of modulo digit counters with terminal-count, wrap and load-clamp flags.
module mod_counter_chain
    import counter_pkg::*;
#(
    parameter int unsigned                   NUM_DIGITS = 2,
    parameter int unsigned                   DIGIT_W    = DIGIT_W_DEF,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] MODULI     = MOD_60
) (
    input  logic               clk,
    input  logic               rst,
    mod_counter_chain_if.slave bus
);

    localparam int unsigned W = NUM_DIGITS * DIGIT_W;

    logic [NUM_DIGITS:0]   step;
    logic [NUM_DIGITS-1:0] at_max;
    logic [NUM_DIGITS-1:0] at_zero;
    logic [NUM_DIGITS-1:0] clamped;
    logic [NUM_DIGITS-1:0] nxt_max;
    logic [NUM_DIGITS-1:0] nxt_zero;
    logic [W-1:0]          count_q;
    logic                  co_q;
    logic                  wrap_q;
    logic                  load_err_q;

    assign step[0] = bus.en & ~bus.load;

    // step[k+1] is the carry/borrow out of digit k; step[NUM_DIGITS] wraps the chain.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        localparam logic [DIGIT_W-1:0] MOD_K = MODULI[k*DIGIT_W +: DIGIT_W];
        localparam logic [DIGIT_W-1:0] MAX_K = MOD_K - DIGIT_W'(1);

        logic [DIGIT_W-1:0] q_nxt;

        mod_digit #(
            .DIGIT_W (DIGIT_W)
        ) u_digit (
            .clk      (clk),
            .rst_n    (rst),
            .step     (step[k]),
            .up_dn    (bus.up_dn),
            .load     (bus.load),
            .load_val (bus.load_val[k*DIGIT_W +: DIGIT_W]),
            .modulus  (MOD_K),
            .q        (count_q[k*DIGIT_W +: DIGIT_W]),
            .q_nxt_c  (q_nxt),
            .at_max   (at_max[k]),
            .at_zero  (at_zero[k]),
            .clamped  (clamped[k])
        );

        assign step[k+1]   = step[k] & (bus.up_dn ? at_max[k] : at_zero[k]);
        assign nxt_max[k]  = (q_nxt == MAX_K);
        assign nxt_zero[k] = (q_nxt == '0);
    end

    // co looks at the value being registered, so it follows loads and direction changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            co_q       <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            co_q       <= bus.up_dn ? (&nxt_max) : (&nxt_zero);
            wrap_q     <= step[NUM_DIGITS];
            load_err_q <= bus.load & (|clamped);
        end
    end

    assign bus.count    = count_q;
    assign bus.co       = co_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_mod_counter_chain.sv
// Scoreboard bench: a mixed-radix integer model predicts each cycle for a 00..59 and a 3-digit chain.
module tb_mod_counter_chain;

    typedef struct packed {
        logic [11:0] count;
        logic        co;
        logic        wrap;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;

    int   total;
    int   passed;
    int   mods[2][8];
    int   nd[2];
    int   mv[2];
    exp_t qa[$];
    exp_t qb[$];

    mod_counter_chain_if #(.W(8))  ifa ();
    mod_counter_chain_if #(.W(12)) ifb ();

    mod_counter_chain u_dut_a (
        .clk (clk),
        .rst (rst_n),
        .bus (ifa)
    );

    mod_counter_chain #(
        .NUM_DIGITS (3),
        .DIGIT_W    (4),
        .MODULI     ({4'd2, 4'd4, 4'd10})
    ) u_dut_b (
        .clk (clk),
        .rst (rst_n),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int chain_total(input int id);
        int t;
        t = 1;
        for (int k = 0; k < nd[id]; k++) t = t * mods[id][k];
        return t;
    endfunction

    function automatic logic [11:0] to_vec(input int id, input int v);
        logic [11:0] r;
        int          x;
        r = '0;
        x = v;
        for (int k = 0; k < nd[id]; k++) begin
            r = r | (12'(x % mods[id][k]) << (4 * k));
            x = x / mods[id][k];
        end
        return r;
    endfunction

    // The chain is an integer in 0..total-1; digits are its mixed-radix representation.
    function automatic exp_t model_step(input int id, input logic en, input logic up,
                                        input logic ld, input logic [11:0] lv);
        exp_t e;
        int   tot;
        int   v;
        int   w;
        int   d;
        e   = '0;
        tot = chain_total(id);
        if (ld) begin
            v = 0;
            w = 1;
            for (int k = 0; k < nd[id]; k++) begin
                d = int'((lv >> (4 * k)) & 12'hF);
                if (d >= mods[id][k]) begin
                    d     = mods[id][k] - 1;
                    e.err = 1'b1;
                end
                v = v + d * w;
                w = w * mods[id][k];
            end
            mv[id] = v;
        end else if (en) begin
            if (up) begin
                e.wrap = (mv[id] == tot - 1);
                mv[id] = (mv[id] + 1) % tot;
            end else begin
                e.wrap = (mv[id] == 0);
                mv[id] = (mv[id] + tot - 1) % tot;
            end
        end
        e.co    = up ? (mv[id] == tot - 1) : (mv[id] == 0);
        e.count = to_vec(id, mv[id]);
        return e;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    task automatic drive(input logic ea, input logic ua, input logic la, input logic [7:0] va,
                         input logic eb, input logic ub, input logic lb, input logic [11:0] vb);
        @(negedge clk);
        ifa.en = ea; ifa.up_dn = ua; ifa.load = la; ifa.load_val = va;
        ifb.en = eb; ifb.up_dn = ub; ifb.load = lb; ifb.load_val = vb;
        qa.push_back(model_step(0, ea, ua, la, {4'h0, va}));
        qb.push_back(model_step(1, eb, ub, lb, vb));
    endtask

    task automatic drive_a(input logic ea, input logic ua, input logic la, input logic [7:0] va);
        drive(ea, ua, la, va, 1'b0, 1'b1, 1'b0, 12'h000);
    endtask

    task automatic compare(input string name, input exp_t e, input logic [11:0] cnt,
                           input logic co, input logic wrap, input logic err);
        total++;
        if (cnt === e.count && co === e.co && wrap === e.wrap && err === e.err) begin
            passed++;
        end else begin
            $display("FAIL %s: got count=%h co=%b wrap=%b load_err=%b, want count=%h co=%b wrap=%b load_err=%b",
                     name, cnt, co, wrap, err, e.count, e.co, e.wrap, e.err);
        end
    endtask

    // Monitors sample 1 ns after each rising edge, once the registered outputs have settled.
    always begin
        @(posedge clk);
        #1;
        if (qa.size() != 0) compare("chain60", qa.pop_front(), {4'h0, ifa.count},
                                    ifa.co, ifa.wrap, ifa.load_err);
    end

    always begin
        @(posedge clk);
        #1;
        if (qb.size() != 0) compare("chain80", qb.pop_front(), ifb.count,
                                    ifb.co, ifb.wrap, ifb.load_err);
    end

    initial begin
        total  = 0;
        passed = 0;
        mods[0] = '{10, 6, 1, 1, 1, 1, 1, 1};
        mods[1] = '{10, 4, 2, 1, 1, 1, 1, 1};
        nd[0]   = 2;
        nd[1]   = 3;
        mv[0]   = 0;
        mv[1]   = 0;
        rst_n   = 1'b0;
        ifa.en = 1'b0; ifa.up_dn = 1'b1; ifa.load = 1'b0; ifa.load_val = '0;
        ifb.en = 1'b0; ifb.up_dn = 1'b1; ifb.load = 1'b0; ifb.load_val = '0;

        #23;
        chk("reset_count_a", {4'h0, ifa.count}, 12'h000);
        chk("reset_flags_a", {9'h0, ifa.co, ifa.wrap, ifa.load_err}, 12'h000);
        chk("reset_count_b", ifb.count, 12'h000);
        chk("reset_flags_b", {9'h0, ifb.co, ifb.wrap, ifb.load_err}, 12'h000);
        #9 rst_n = 1'b1;

        // Up sweep past the wrap: 01..59, 00, 01.
        for (int i = 0; i < 61; i++) drive_a(1'b1, 1'b1, 1'b0, 8'h00);
        // Load 00 then count down through the borrow.
        drive_a(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) drive_a(1'b1, 1'b0, 1'b0, 8'h00);
        // Load beats enable, then a normal step.
        drive_a(1'b1, 1'b1, 1'b1, 8'h45);
        drive_a(1'b1, 1'b1, 1'b0, 8'h00);
        // Both digits out of range are clamped to 59.
        drive_a(1'b0, 1'b1, 1'b1, 8'h9C);
        drive_a(1'b0, 1'b1, 1'b0, 8'h00);
        drive_a(1'b0, 1'b0, 1'b0, 8'h00);
        drive_a(1'b0, 1'b0, 1'b1, 8'h00);
        drive_a(1'b0, 1'b1, 1'b1, 8'hFF);
        // Count to 37, then reset between edges.
        drive_a(1'b0, 1'b1, 1'b1, 8'h30);
        for (int i = 0; i < 7; i++) drive_a(1'b1, 1'b1, 1'b0, 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", {4'h0, ifa.count}, 12'h000);
        chk("async_rst_co", {11'h0, ifa.co}, 12'h000);
        mv[0] = 0;
        mv[1] = 0;
        #1 rst_n = 1'b1;
        drive_a(1'b1, 1'b1, 1'b0, 8'h00);

        // Three-digit chain: full sweep of 80 states plus the wrap.
        for (int i = 0; i < 82; i++)
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 12'h000);
        for (int i = 0; i < 20; i++)
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 12'h000);

        // Random mix of steps, direction changes, holds and loads on both chains.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 11) == 0, 8'($urandom),
                  $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 11) == 0, 12'($urandom));
        end

        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drained", 12'(qa.size() + qb.size()), 12'h000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
